// File: rtl/maxpool_row_pair_pkg.sv
// Shared definitions for the maxpool row-pairing stage: bus width macros,
// FSM state encoding and sizing defaults.
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
`ifndef AXI_WIDTH_DATA_IN
`define AXI_WIDTH_DATA_IN (16 * `PICTURE_NUM * 8)
`endif

package maxpool_row_pair_pkg;

  localparam int RE_CH_DEF        = 16;
  localparam int DATA_W_DEF       = `AXI_WIDTH_DATA_IN;
  localparam int MAX_COL_DEF      = 640;
  localparam int MAX_CH_BEATS_DEF = 8;
  localparam int DIM_W_DEF        = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EVEN  = 3'd1,
    ST_ODD   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DROP  = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

endpackage

// File: rtl/maxpool_row_pair_line_ram.sv
// Simple dual-port line buffer: one write port, one registered read port
// whose output holds its value while the read enable is low.
module maxpool_line_ram #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 5120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] rdata_r;

  // storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // registered read port, held when no read is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {DATA_W{1'b0}};
    end else if (re) begin
      rdata_r <= mem[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/maxpool_row_pair.sv
// Vertical pairing stage for 2x2/stride-2 maxpool: buffers each even row and
// emits (even, odd) same-position beat pairs while the odd row streams in.
module maxpool_row_pair
  import maxpool_row_pair_pkg::*;
#(
  parameter int RE_CHANNEL_IN_NUM = RE_CH_DEF,
  parameter int DATA_W            = RE_CHANNEL_IN_NUM * `PICTURE_NUM * 8,
  parameter int MAX_COL           = MAX_COL_DEF,
  parameter int MAX_CH_BEATS      = MAX_CH_BEATS_DEF,
  parameter int ADDR_W            = $clog2(MAX_COL * MAX_CH_BEATS),
  parameter int DIM_W             = DIM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIM_W-1:0]  col_num,
  input  logic [DIM_W-1:0]  row_num,
  input  logic [3:0]        ch_beats,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data_1,
  output logic [DATA_W-1:0] m_data_2,
  output logic              busy,
  output logic              done
);

  localparam int LEN_W = DIM_W + 4;

  state_t            state_r, state_nxt_s;
  logic [DIM_W-1:0]  col_r, row_r, row_cnt_r;
  logic [3:0]        ch_r;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  len_s;
  logic [DIM_W:0]    pair_rows_s;
  logic              more_pairs_s;
  logic              last_s, accept_s, s_ready_s, odd_acc_s, wr_en_s, start_acc_s;
  logic              m_valid_r, busy_r, done_r;
  logic [DATA_W-1:0] m_data_2_r, rd_data_s;

  assign len_s        = LEN_W'(col_r) * LEN_W'(ch_r);
  assign last_s       = (LEN_W'(addr_r) == (len_s - LEN_W'(1)));
  assign accept_s     = s_valid & s_ready_s;
  assign odd_acc_s    = accept_s & (state_r == ST_ODD);
  assign wr_en_s      = accept_s & (state_r == ST_EVEN);
  assign start_acc_s  = start & (state_r == ST_IDLE);
  // rows consumed once the current odd row completes, and whether a full pair remains
  assign pair_rows_s  = {1'b0, row_cnt_r} + (DIM_W+1)'(2);
  assign more_pairs_s = ((pair_rows_s + (DIM_W+1)'(2)) <= {1'b0, row_r});

  // next-state and input-ready decode
  always_comb begin
    state_nxt_s = state_r;
    s_ready_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((col_num == DIM_W'(0)) || (ch_beats == 4'd0) || (row_num == DIM_W'(0))) begin
            state_nxt_s = ST_FIN;
          end else if (row_num < DIM_W'(2)) begin
            state_nxt_s = ST_DROP;
          end else begin
            state_nxt_s = ST_EVEN;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EVEN: begin
        s_ready_s = 1'b1;
        if (s_valid && last_s) begin
          state_nxt_s = ST_ODD;
        end else begin
          state_nxt_s = ST_EVEN;
        end
      end
      ST_ODD: begin
        s_ready_s = !m_valid_r || m_ready;
        if (s_ready_s && s_valid && last_s) begin
          if (more_pairs_s) begin
            state_nxt_s = ST_EVEN;
          end else if (row_r[0]) begin
            state_nxt_s = ST_DROP;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_ODD;
        end
      end
      ST_DROP: begin
        s_ready_s = 1'b1;
        if (s_valid && last_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_DROP;
        end
      end
      ST_DRAIN: begin
        if (!m_valid_r || m_ready) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // state, frame parameters, counters and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      col_r     <= {DIM_W{1'b0}};
      row_r     <= {DIM_W{1'b0}};
      ch_r      <= 4'd0;
      addr_r    <= {ADDR_W{1'b0}};
      row_cnt_r <= {DIM_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_r == ST_FIN);
      if (start_acc_s) begin
        col_r     <= col_num;
        row_r     <= row_num;
        ch_r      <= ch_beats;
        addr_r    <= {ADDR_W{1'b0}};
        row_cnt_r <= {DIM_W{1'b0}};
        busy_r    <= 1'b1;
      end else if (state_r == ST_FIN) begin
        busy_r <= 1'b0;
      end
      if (accept_s) begin
        addr_r <= last_s ? {ADDR_W{1'b0}} : (addr_r + ADDR_W'(1));
        if ((state_r == ST_ODD) && last_s) begin
          row_cnt_r <= pair_rows_s[DIM_W-1:0];
        end
      end
    end
  end

  // output pair register: odd-row beat plus valid flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_r  <= 1'b0;
      m_data_2_r <= {DATA_W{1'b0}};
    end else if (odd_acc_s) begin
      m_valid_r  <= 1'b1;
      m_data_2_r <= s_data;
    end else if (m_ready) begin
      m_valid_r  <= 1'b0;
    end
  end

  maxpool_line_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (MAX_COL * MAX_CH_BEATS)
  ) u_line_ram (
    .clk   (clk),
    .rst_n (rst),
    .we    (wr_en_s),
    .waddr (addr_r),
    .wdata (s_data),
    .re    (odd_acc_s),
    .raddr (addr_r),
    .rdata (rd_data_s)
  );

  assign s_ready  = s_ready_s;
  assign m_valid  = m_valid_r;
  assign m_data_1 = rd_data_s;
  assign m_data_2 = m_data_2_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_maxpool_row_pair.sv
// Scoreboard bench for maxpool_row_pair: frames of beats are built as rows,
// expected pairs come from pairing row 2k with row 2k+1 column by column.
module tb_maxpool_row_pair;
  import maxpool_row_pair_pkg::*;

  localparam int DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          rst, start, s_valid, s_ready, m_valid, m_ready, busy, done;
  logic [11:0]   col_num, row_num;
  logic [3:0]    ch_beats;
  logic [DW-1:0] s_data, m_data_1, m_data_2;

  typedef struct { logic [DW-1:0] d1; logic [DW-1:0] d2; } pair_t;
  pair_t         exp_q[$];
  logic [DW-1:0] beats[$];
  int            checks = 0, errors = 0, done_cnt = 0, rmode = 0;
  logic          stall = 1'b0;
  logic [DW-1:0] hold_d1, hold_d2;
  pair_t         cur;

  always #5 clk = ~clk;

  maxpool_row_pair dut (
    .clk(clk), .rst(rst), .start(start), .col_num(col_num), .row_num(row_num),
    .ch_beats(ch_beats), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_1(m_data_1), .m_data_2(m_data_2),
    .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [DW-1:0] idx_beat(input int j);
    logic [7:0] b;
    b = 8'(j);
    return {(DW/8){b}};
  endfunction

  // downstream ready generator
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // monitor: pops the scoreboard on every handshake and checks stall stability
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", m_valid, 1'b1);
          chk("hold_d1", m_data_1, hold_d1);
          chk("hold_d2", m_data_2, hold_d2);
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_pair actual=%0h/%0h required=none", m_data_1, m_data_2);
          end else begin
            cur = exp_q.pop_front();
            chk("pair_d1", m_data_1, cur.d1);
            chk("pair_d2", m_data_2, cur.d2);
          end
        end
        if (done) done_cnt++;
        stall   = m_valid && !m_ready;
        hold_d1 = m_data_1;
        hold_d2 = m_data_2;
      end
    end
  end

  task automatic drive_beat(input logic [DW-1:0] d, input bit odd);
    bit got;
    got = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (odd) chk("s_ready_odd", s_ready, !(m_valid && !m_ready));
      else     chk("s_ready_even", s_ready, 1'b1);
      got = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL beat_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic pulse_start(input int col, input int row, input int ch);
    @(posedge clk); #1;
    col_num = 12'(col); row_num = 12'(row); ch_beats = 4'(ch);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input int col, input int row, input int ch,
                           input bit rnd, input int rm, input bit gaps, input bit restart);
    int L, n, prev, r;
    L = col * ch;
    n = L * row;
    prev = done_cnt;
    rmode = rm;
    beats.delete();
    for (int j = 0; j < n; j++) beats.push_back(rnd ? rnd_beat() : idx_beat(j));
    for (int k = 0; k < row / 2; k++)
      for (int i = 0; i < L; i++) begin
        cur.d1 = beats[(2 * k) * L + i];
        cur.d2 = beats[(2 * k + 1) * L + i];
        exp_q.push_back(cur);
      end
    pulse_start(col, row, ch);
    chk("busy_after_start", busy, 1'b1);
    if (n == 0) begin
      chk("done_early", done, 1'b0);
      @(posedge clk); #1;
      chk("done_2cyc", done, 1'b1);
      chk("busy_at_done", busy, 1'b0);
      @(posedge clk); #1;
      chk("done_pulse", done, 1'b0);
    end else begin
      for (int j = 0; j < n; j++) begin
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        if (restart && j == n / 2) begin
          col_num = 12'd1; row_num = 12'd2; ch_beats = 4'd1; start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
        r = j / L;
        drive_beat(beats[j], (r % 2 == 1) && (r < (row / 2) * 2));
      end
      for (int t = 0; t < 300 && done_cnt == prev; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
    end
    chk("done_count", done_cnt, prev + 1);
    chk("pairs_left", exp_q.size(), 0);
    chk("busy_end", busy, 1'b0);
    exp_q.delete();
    rmode = 0;
  endtask

  task automatic reset_mid_odd();
    rmode = 2;
    exp_q.delete();
    pulse_start(4, 4, 1);
    for (int j = 0; j < 4; j++) drive_beat(rnd_beat(), 1'b0);
    drive_beat(rnd_beat() | {{(DW-1){1'b0}}, 1'b1}, 1'b1);
    chk("mid_m_valid", m_valid, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data_1", m_data_1, '0);
    chk("rst_m_data_2", m_data_2, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_ready", s_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    rmode = 0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0;
    col_num = '0; row_num = '0; ch_beats = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_m_valid", m_valid, 1'b0);
    chk("reset_s_ready", s_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_d1", m_data_1, '0);
    chk("reset_d2", m_data_2, '0);
    rst = 1'b1;

    run_frame(4, 2, 1, 1'b0, 0, 1'b0, 1'b0);
    run_frame(2, 4, 2, 1'b0, 0, 1'b0, 1'b0);
    run_frame(3, 3, 1, 1'b1, 0, 1'b0, 1'b0);
    run_frame(5, 6, 3, 1'b1, 1, 1'b1, 1'b1);
    run_frame(1, 5, 8, 1'b1, 1, 1'b0, 1'b0);
    run_frame(4, 1, 1, 1'b1, 1, 1'b0, 1'b0);
    run_frame(0, 4, 1, 1'b1, 0, 1'b0, 1'b0);
    run_frame(3, 2, 0, 1'b1, 0, 1'b0, 1'b0);
    run_frame(3, 0, 2, 1'b1, 0, 1'b0, 1'b0);
    reset_mid_odd();
    run_frame(4, 4, 1, 1'b1, 1, 1'b0, 1'b0);
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(1, 6), $urandom_range(1, 5), $urandom_range(1, 4),
                1'b1, 1, 1'($urandom_range(0, 1)), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maxpool_row_pair.md
Name: maxpool_row_pair

Overview:
- Upstream vertical-pairing stage for the per-lane max comparator array in the 2x2/stride-2 maxpool path.
- Accepts a raster-order stream of channel-sliced pixel vectors and stores each even row in a line buffer.
- On the following odd row, emits (buffered pixel, incoming pixel) pairs with a valid/ready handshake, so the comparator receives same-column pixels from rows 2k and 2k+1.

Parameters:
- RE_CHANNEL_IN_NUM, 16: 8-bit lanes per picture in one beat.
- DATA_W, `AXI_WIDTH_DATA_IN: beat width, equal to RE_CHANNEL_IN_NUM*`PICTURE_NUM*8.
- MAX_COL, 640: maximum columns per row.
- MAX_CH_BEATS, 8: maximum beats per pixel (channel slices).
- ADDR_W, clog2(MAX_COL*MAX_CH_BEATS): line buffer address width.
- DIM_W, 12: width of the row/col count inputs.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle pulse; latches col_num, row_num, ch_beats.
- col_num, in, DIM_W: columns per row.
- row_num, in, DIM_W: rows per feature map.
- ch_beats, in, 4: beats per pixel (1..MAX_CH_BEATS).
- s_valid, in, 1: input beat valid.
- s_ready, out, 1: input beat accepted when s_valid & s_ready.
- s_data, in, DATA_W: input beat.
- m_valid, out, 1: pair valid.
- m_ready, in, 1: downstream accepts pair.
- m_data_1, out, DATA_W: beat from even row (line buffer).
- m_data_2, out, DATA_W: same-position beat from odd row.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse at end of frame.

Behaviour:
- Reset: state=IDLE; s_ready, m_valid, busy, done = 0; m_data_1/m_data_2 = 0; all counters = 0. Reset mid-frame aborts immediately. Line buffer contents are don't-care.
- Row length: L = col_num*ch_beats beats. Linear addr counter runs 0..L-1 and clears at end of each row. row_cnt counts rows.
- FSM states: IDLE, EVEN, ODD, DRAIN, DROP, FIN.
- IDLE:
  - start -> latch parameters, busy=1.
  - If col_num=0, ch_beats=0 or row_num=0 -> FIN.
  - Else if row_num<2 -> DROP.
  - Else -> EVEN.
  - start while busy is ignored.
- EVEN:
  - s_ready=1.
  - Each accepted beat writes RAM[addr].
  - No output is produced.
  - After beat L-1 -> ODD.
- ODD:
  - s_ready = !m_valid | m_ready.
  - An accepted beat issues RAM read of addr and registers s_data into m_data_2; m_valid=1 next cycle.
  - m_data_1 is the sync-read RAM output (1-cycle latency). It is held stable because reads occur only on accept.
  - m_valid clears on m_ready when no new accept occurs in that cycle.
  - A new accept in the same cycle as m_ready gives back-to-back throughput of 1 pair/cycle.
- Row end:
  - After beat L-1 of an odd row, row_cnt += 2.
  - If row_cnt+2 <= row_num -> EVEN.
  - Else if row_num is odd -> DROP (the last unpaired row is consumed and discarded).
  - Else -> DRAIN.
- DROP:
  - s_ready=1.
  - Discards L beats -> DRAIN.
- DRAIN: waits until m_valid=0 (last pair handed off) -> FIN.
- FIN: done=1 for one cycle, busy=0 -> IDLE.
- Pairing latency: input accept to m_valid is exactly 1 cycle.
- Total pairs per frame: floor(row_num/2)*L.
- Ordering: pairs are emitted strictly in input order.
- Widths: addr is never compared beyond L-1. Parameters exceeding MAX_COL/MAX_CH_BEATS are unsupported and are not checked.

Decomposition:
- Shared package/include holds: `AXI_WIDTH_DATA_IN, `PICTURE_NUM, the FSM state encodings, MAX_COL and MAX_CH_BEATS defaults.
- One natural sub-module: maxpool_line_ram, a simple dual-port RAM with DATA_W data, ADDR_W address, 1-cycle registered read, and read output held when read enable is low.

Test Plan:
- col=4, row=2, ch_beats=1, beats 0..7 (byte lanes = beat index), m_ready=1 -> 4 pairs: (0,4),(1,5),(2,6),(3,7); done one cycle after the last pair is accepted.
- col=2, row=4, ch_beats=2, 16 beats, m_ready=1 -> 8 pairs: rows 0/1 then rows 2/3; beat order preserved within each pixel.
- col=3, row=3, ch_beats=1 -> 3 pairs; row 2 is accepted with s_ready=1 and produces no output; done after row 2 is consumed.
- Random m_ready (50%) during odd rows -> no pair lost or duplicated; m_data_1/m_data_2 stable while m_valid=1 & m_ready=0; s_ready low exactly when m_valid=1 & m_ready=0.
- row=1 or col=0 -> no output; done pulses (col=0: 2 cycles after start); a start pulse while busy is ignored.
- rst asserted mid-ODD with m_valid=1 -> outputs 0 immediately; a new start then runs a clean frame with correct pairs.
